// File: rtl/uart_rx_byte_fifo.sv
// rtl/uart_rx_byte_fifo.sv - receive-byte FIFO between a UART receiver and a valid/ready consumer
//
// Purpose:
//    Captures each received byte with its 2-bit error status on the rising edge
//    of rx_complete. Bytes are buffered in a 2^DEPTH_LOG2-entry
//    first-word-fall-through FIFO and presented over a valid/ready interface.
//    Fill level, almost-full, a sticky overflow flag and a saturating drop
//    counter are reported so lost bytes are always visible.
//
// Ports:
//    system_clk    in   system clock, rising edge
//    reset         in   asynchronous active-low reset
//    rx_complete   in   byte-done strobe (may stay high for several cycles)
//    rx_data       in   [7:0] received byte
//    rx_error_bit  in   [1:0] receiver status, nonzero = error
//    m_valid       out  head entry available
//    m_data        out  [7:0] head byte, 0 when m_valid=0
//    m_err         out  [1:0] head status, 0 when m_valid=0
//    m_ready       in   consumer accepts head when m_valid & m_ready
//    level         out  [DEPTH_LOG2:0] number of stored entries
//    almost_full   out  level >= AFULL_LEVEL
//    overflow      out  sticky, a byte was lost to a full FIFO
//    drop_count    out  [7:0] saturating count of lost or discarded bytes
//    clr_overflow  in   synchronous clear of overflow and drop_count

module uart_rx_byte_fifo #(
   parameter int DEPTH_LOG2  = 4,
   parameter int AFULL_LEVEL = 12,
   parameter int DROP_ERR    = 0
) (
   input  logic                  system_clk,
   input  logic                  reset,
   input  logic                  rx_complete,
   input  logic [7:0]            rx_data,
   input  logic [1:0]            rx_error_bit,
   output logic                  m_valid,
   output logic [7:0]            m_data,
   output logic [1:0]            m_err,
   input  logic                  m_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  almost_full,
   output logic                  overflow,
   output logic [7:0]            drop_count,
   input  logic                  clr_overflow
);

   localparam int                LP_ENTRIES = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LP_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] LP_AFULL = AFULL_LEVEL[DEPTH_LOG2:0];

   logic [9:0]            r_mem [0:LP_ENTRIES-1];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_rx_complete_d;
   logic                  r_overflow;
   logic [7:0]            r_drop_count;

   logic                  w_push_req;
   logic                  w_err_drop;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_push_ok;
   logic                  w_ovf_drop;
   logic                  w_drop;
   logic [9:0]            w_head;

   // Only the rising edge of the strobe pushes, so a long pulse stores once.
   assign w_push_req = rx_complete & ~r_rx_complete_d;
   assign w_err_drop = (DROP_ERR != 0) & w_push_req & (rx_error_bit != 2'b00);
   assign w_pop      = m_valid & m_ready;
   assign w_full     = (r_level == LP_FULL);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push_ok  = w_push_req & ~w_err_drop & (~w_full | w_pop);
   assign w_ovf_drop = w_push_req & ~w_err_drop & w_full & ~w_pop;
   assign w_drop     = w_err_drop | w_ovf_drop;

   // Storage is deliberately not reset; level alone says what is valid.
   always_ff @(posedge system_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= {rx_error_bit, rx_data};
      end
   end

   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_level         <= '0;
         // Start "high" so a strobe already asserted at reset release is ignored.
         r_rx_complete_d <= 1'b1;
         r_overflow      <= 1'b0;
         r_drop_count    <= 8'h00;
      end else begin
         r_rx_complete_d <= rx_complete;

         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         if (w_push_ok && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_push_ok && w_pop) begin
            r_level <= r_level - 1'b1;
         end

         // A drop in the same cycle as a clear wins over the clear.
         if (w_ovf_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end

         if (w_drop) begin
            if (clr_overflow) begin
               r_drop_count <= 8'h01;
            end else if (r_drop_count != 8'hFF) begin
               r_drop_count <= r_drop_count + 8'h01;
            end
         end else if (clr_overflow) begin
            r_drop_count <= 8'h00;
         end
      end
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign m_valid     = (r_level != '0);
   assign m_data      = m_valid ? w_head[7:0] : 8'h00;
   assign m_err       = m_valid ? w_head[9:8] : 2'b00;
   assign level       = r_level;
   assign almost_full = (r_level >= LP_AFULL);
   assign overflow    = r_overflow;
   assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// tb/tb_uart_rx_byte_fifo.sv - scoreboard bench for uart_rx_byte_fifo with DROP_ERR=0 and DROP_ERR=1

module tb_uart_rx_byte_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rc;
   logic [7:0] rd;
   logic [1:0] re;
   logic       m_ready;
   logic       clr;

   logic       mv  [2];
   logic [7:0] md  [2];
   logic [1:0] me  [2];
   logic [4:0] lvl [2];
   logic       af  [2];
   logic       ovf [2];
   logic [7:0] dcnt[2];

   int checks = 0;
   int errors = 0;

   // Reference model: one queue of expected entries per DUT plus flag state.
   logic [9:0] sb_q [2][$];
   bit         m_prev [2];
   bit         m_ovf  [2];
   int         m_dc   [2];

   always #5 clk = ~clk;

   uart_rx_byte_fifo #(.DEPTH_LOG2(4), .AFULL_LEVEL(12), .DROP_ERR(0)) dut0 (
      .system_clk(clk), .reset(rst_n), .rx_complete(rc), .rx_data(rd),
      .rx_error_bit(re), .m_valid(mv[0]), .m_data(md[0]), .m_err(me[0]),
      .m_ready(m_ready), .level(lvl[0]), .almost_full(af[0]),
      .overflow(ovf[0]), .drop_count(dcnt[0]), .clr_overflow(clr));

   uart_rx_byte_fifo #(.DEPTH_LOG2(4), .AFULL_LEVEL(12), .DROP_ERR(1)) dut1 (
      .system_clk(clk), .reset(rst_n), .rx_complete(rc), .rx_data(rd),
      .rx_error_bit(re), .m_valid(mv[1]), .m_data(md[1]), .m_err(me[1]),
      .m_ready(m_ready), .level(lvl[1]), .almost_full(af[1]),
      .overflow(ovf[1]), .drop_count(dcnt[1]), .clr_overflow(clr));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: at each falling edge compare outputs with the model, then
   // advance the model by what the next rising edge will see.
   task automatic step(input int d);
      int         sz;
      logic [9:0] head;
      bit         push_req, pop, full;
      if (!rst_n) begin
         sb_q[d].delete();
         m_prev[d] = 1'b1;
         m_ovf[d]  = 1'b0;
         m_dc[d]   = 0;
      end
      sz   = sb_q[d].size();
      head = (sz != 0) ? sb_q[d][0] : 10'h000;
      chk($sformatf("dut%0d.level", d), int'(lvl[d]), sz);
      chk($sformatf("dut%0d.m_valid", d), int'(mv[d]), int'(sz != 0));
      chk($sformatf("dut%0d.m_data", d), int'(md[d]), int'(head[7:0]));
      chk($sformatf("dut%0d.m_err", d), int'(me[d]), int'(head[9:8]));
      chk($sformatf("dut%0d.almost_full", d), int'(af[d]), int'(sz >= 12));
      chk($sformatf("dut%0d.overflow", d), int'(ovf[d]), int'(m_ovf[d]));
      chk($sformatf("dut%0d.drop_count", d), int'(dcnt[d]), m_dc[d]);
      if (rst_n) begin
         push_req  = rc && !m_prev[d];
         m_prev[d] = rc;
         full      = (sz == 16);
         pop       = (sz != 0) && m_ready;
         if (pop) void'(sb_q[d].pop_front());
         if (clr) begin
            m_ovf[d] = 1'b0;
            m_dc[d]  = 0;
         end
         if (push_req) begin
            if (d == 1 && re != 2'b00) begin
               m_dc[d] = (m_dc[d] < 255) ? m_dc[d] + 1 : 255;
            end else if (full && !pop) begin
               m_ovf[d] = 1'b1;
               m_dc[d]  = (m_dc[d] < 255) ? m_dc[d] + 1 : 255;
            end else begin
               sb_q[d].push_back({re, rd});
            end
         end
      end
   endtask

   always @(negedge clk) begin
      step(0);
      step(1);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic strobe(input logic [7:0] data, input logic [1:0] err, input int width);
      rc = 1'b1;
      rd = data;
      re = err;
      repeat (width) cyc();
      rc = 1'b0;
      cyc();
   endtask

   task automatic drain(input int n);
      m_ready = 1'b1;
      repeat (n) cyc();
      m_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rc = 1'b0; rd = 8'h00; re = 2'b00; m_ready = 1'b0; clr = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      // Single byte: visible the cycle after capture, gone after one pop.
      strobe(8'hA5, 2'b00, 1);
      chk("t1.m_valid", int'(mv[0]), 1);
      chk("t1.m_data", int'(md[0]), 8'hA5);
      chk("t1.level", int'(lvl[0]), 1);
      drain(1);
      chk("t1.level_after_pop", int'(lvl[0]), 0);
      chk("t1.m_data_after_pop", int'(md[0]), 0);

      // Long strobe stores once.
      strobe(8'h3C, 2'b00, 5);
      chk("t2.level", int'(lvl[0]), 1);
      drain(1);

      // Fill to full, overflow by one, drain in order.
      for (int i = 0; i < 16; i++) begin
         strobe(8'(i), 2'b00, 1);
         if (i == 10) chk("t3.afull_before", int'(af[0]), 0);
         if (i == 11) chk("t3.afull_at_12", int'(af[0]), 1);
      end
      chk("t3.level_full", int'(lvl[0]), 16);
      strobe(8'h10, 2'b00, 1);
      chk("t3.overflow", int'(ovf[0]), 1);
      chk("t3.drop_count", int'(dcnt[0]), 1);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t3.drain_order", int'(md[0]), i);
         cyc();
      end
      m_ready = 1'b0;
      chk("t3.empty", int'(mv[0]), 0);
      pulse_clr();
      chk("t3.overflow_cleared", int'(ovf[0]), 0);

      // Errored byte: stored by dut0, discarded by dut1.
      strobe(8'h5A, 2'b10, 1);
      chk("t4.m_data", int'(md[0]), 8'h5A);
      chk("t4.m_err", int'(me[0]), 2);
      chk("t4.drop_level", int'(lvl[1]), 0);
      chk("t4.drop_count", int'(dcnt[1]), 1);
      chk("t4.drop_no_ovf", int'(ovf[1]), 0);
      drain(1);
      pulse_clr();

      // Full plus simultaneous push/pop.
      for (int i = 0; i < 16; i++) strobe(8'(8'h40 + i), 2'b00, 1);
      rc = 1'b1; rd = 8'h77; re = 2'b00; m_ready = 1'b1;
      cyc();
      rc = 1'b0; m_ready = 1'b0;
      cyc();
      chk("t5.level", int'(lvl[0]), 16);
      chk("t5.no_ovf", int'(ovf[0]), 0);
      // Overflow once, then a drop coinciding with clear.
      strobe(8'hEE, 2'b00, 1);
      chk("t5.dc_one", int'(dcnt[0]), 1);
      rc = 1'b1; rd = 8'hEF; clr = 1'b1;
      cyc();
      rc = 1'b0; clr = 1'b0;
      cyc();
      chk("t5.set_wins_ovf", int'(ovf[0]), 1);
      chk("t5.set_wins_dc", int'(dcnt[0]), 1);
      m_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         chk("t5.older", int'(md[0]), 8'h41 + i);
         cyc();
      end
      chk("t5.last_77", int'(md[0]), 8'h77);
      cyc();
      m_ready = 1'b0;
      pulse_clr();

      // Asynchronous reset with data stored and a strobe held across release.
      for (int i = 0; i < 5; i++) strobe(8'(8'h90 + i), 2'b00, 1);
      chk("t6.level5", int'(lvl[0]), 5);
      rc = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("t6.async_mv0", int'(mv[0]), 0);
      chk("t6.async_lvl0", int'(lvl[0]), 0);
      chk("t6.async_mv1", int'(mv[1]), 0);
      chk("t6.async_md0", int'(md[0]), 0);
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("t6.held_not_captured", int'(lvl[0]), 0);
      rc = 1'b0;
      cyc();

      // Randomized traffic in phases of slow, medium and fast consumers.
      for (int i = 0; i < 3000; i++) begin
         int pct;
         pct     = ((i / 300) % 3 == 0) ? 10 : (((i / 300) % 3 == 1) ? 50 : 90);
         rc      = $urandom_range(0, 1);
         rd      = 8'($urandom);
         re      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         m_ready = ($urandom_range(0, 99) < pct);
         clr     = ($urandom_range(0, 63) == 0);
         cyc();
      end
      rc = 1'b0; m_ready = 1'b0; clr = 1'b0;
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
